// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation controller.
package sar_pkg;

    localparam int SAR_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sar_controller.sv
// Successive-approximation controller driving a magnitude comparator, MSB first.
// Optional build macro SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equal.
module sar_controller
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_greater,
    input  logic             cmp_lesser,
    input  logic             cmp_equal,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cmp_err,
    output state_e           dbg_state
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   trial_q, trial_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cmp_err_q, cmp_err_d;
    logic               early_exit;
    logic               flags_onehot;

    assign flags_onehot = $onehot({cmp_greater, cmp_lesser, cmp_equal});

`ifdef SAR_EARLY_EXIT_EN
    assign early_exit = cmp_equal & ~cmp_greater & ~cmp_lesser;
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            trial_q   <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            cmp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            trial_q   <= trial_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            cmp_err_q <= cmp_err_d;
        end
    end

    // start is a one-way strobe: it is taken on any edge where the block is not
    // busy (IDLE or DONE) and is silently dropped while a conversion is running.
    always_comb begin
        state_d   = state_q;
        trial_d   = trial_q;
        idx_d     = idx_q;
        result_d  = result_q;
        cmp_err_d = cmp_err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d            = TEST;
                    trial_d            = '0;
                    trial_d[WIDTH-1]   = 1'b1;
                    idx_d              = IDX_W'(WIDTH - 1);
                    cmp_err_d          = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                    trial_d = '0;
                end
            end
            TEST: begin
                if (!flags_onehot) begin
                    cmp_err_d = 1'b1;
                end
                // Lesser wins over any other flag, even when the flags are corrupt.
                if (cmp_lesser) begin
                    trial_d[idx_q] = 1'b0;
                end
                if (early_exit) begin
                    result_d = trial_q;
                    state_d  = DONE;
                end else if (idx_q != '0) begin
                    trial_d[idx_q - 1'b1] = 1'b1;
                    idx_d                 = idx_q - 1'b1;
                end else begin
                    result_d = trial_d;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                trial_d = '0;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == TEST);
        done      = (state_q == DONE);
        trial     = trial_q;
        result    = result_q;
        cmp_err   = cmp_err_q;
        dbg_state = state_q;
    end

endmodule

// File: doc/sar_controller.md
# sar_controller

Successive-approximation controller: the driving end of the 4-bit magnitude comparator interface. It generates a trial code on the comparator's B operand and reads back the greater/lesser/equal flags, one bit per cycle, MSB first. It converges on the unknown value presented on the comparator's A operand. It sits beside the comparator and hands a registered result plus a done pulse to downstream logic.

## Interface
- WIDTH, 4, code width in bits; must match the comparator operand width.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous to clk, active-high.
- start  input  1  begins a conversion; accepted only in IDLE or DONE.
- cmp_greater  input  1  comparator flag: unknown (A) > trial (B).
- cmp_lesser  input  1  comparator flag: unknown (A) < trial (B).
- cmp_equal  input  1  comparator flag: unknown (A) == trial (B).
- trial  output  WIDTH  current trial code; drives the comparator B operand.
- busy  output  1  high while in TEST.
- done  output  1  one-cycle pulse when result is updated.
- result  output  WIDTH  last converged code; holds until the next done.
- cmp_err  output  1  sticky: flags were not one-hot during a TEST cycle; cleared by an accepted start.

## Operation
- States:
  - IDLE: trial=0, busy=0.
  - TEST: one comparison per cycle, pointer idx from WIDTH-1 down to 0.
  - DONE: done=1, lasts one cycle.
- IDLE/DONE with start=1: trial = 1<<(WIDTH-1), idx=WIDTH-1, cmp_err=0, go to TEST.
- DONE with start=0: go to IDLE.
- In TEST, each cycle samples the flags against the current trial:
  - cmp_lesser=1: clear trial[idx]. Otherwise keep it; lesser has priority.
  - idx>0: set trial[idx-1] and decrement idx.
  - idx==0: load result with the final trial, go to DONE.
- In TEST, any flag set that is not exactly one-hot sets cmp_err. Decoding continues with the priority rule above.
- start while in TEST is ignored; there is no abort other than rst.
- Arithmetic: pure bit set/clear, no adders. Trial never exceeds 2^WIDTH-1.

## Timing
- Reset values: trial=0, busy=0, done=0, result=0, cmp_err=0, state=IDLE.
- rst asserted mid-conversion forces the reset values on the next edge. The partial conversion is discarded and result is cleared.
- Comparator is combinational: flags are valid in the same cycle the trial is presented and are sampled at the next edge.
- Latency, without early exit:
  - start sampled at edge k.
  - TEST occupies cycles k+1 .. k+WIDTH.
  - result and done are valid in cycle k+WIDTH+1.
- Back-to-back: start held high in DONE restarts at once, so throughput is one conversion per WIDTH+1 cycles.
- done is never high for two consecutive cycles.

## Configuration
- SAR_EARLY_EXIT_EN defined: in TEST, cmp_equal=1 with the other flags low loads result=trial and goes to DONE on that edge. Latency becomes (bits tested)+1 cycles.
- SAR_EARLY_EXIT_EN undefined: equal is treated as "keep bit". Conversion always takes WIDTH TEST cycles.
- The final result is identical in both builds; only latency differs.

## Structure
- Package sar_pkg:
  - state enum {IDLE, TEST, DONE}.
  - SAR_WIDTH_DEFAULT=4.
- Single flat module; no sub-module. The comparator is instantiated alongside it by the parent or bench, not inside this block.

## Test plan
- A=4'b1011, start pulse at cycle 0 -> trial sequence 1000, 1100, 1010, 1011; done at cycle 5; result=1011; cmp_err=0.
- A=0 and then A=15 -> result=0000 and result=1111 respectively; each done at cycle 5.
- Early exit, A=4'b1000:
  - with SAR_EARLY_EXIT_EN: done at cycle 2, result=1000.
  - without it: done at cycle 5, result=1000.
- rst asserted at cycle 3 of a conversion -> next cycle trial=0, busy=0, result=0, no done pulse. A fresh start converts correctly.
- Forced flags greater=1 and lesser=1 in TEST cycle 2 -> cmp_err=1 and stays 1 after done; the next start clears it.
- start held continuously for A=4'b0110 -> conversions complete every 5 cycles, each result=0110; start during TEST has no effect.
